// File: rtl/back_end_mc.sv
// back_end_mc: multi-channel output back end for the co-processor wrapper.
// Each output channel runs its own IDLE/WORK/DONE controller. The controller
// accepts a fixed number of tokens into a local output memory, then waits in
// DONE until every channel has finished. done_all pulses once when that
// happens.
//
// Handshake per channel i: the actor presents a token with wr[i]. The token is
// accepted in the same cycle only when full[i]=0, and wren[i] then mirrors
// wr[i] combinationally. A wr[i] seen while full[i]=1 is dropped: it has no
// write and no count change. The actor must treat full[i] as "not accepting".
module back_end_mc #(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 10,
  localparam int SIZE_W = ADDR_W + 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       start,
  input  logic                       clear,
  input  logic [NUM_CH*SIZE_W-1:0]   size,
  input  logic [NUM_CH-1:0]          wr,
  output logic [NUM_CH-1:0]          wren,
  output logic [NUM_CH*ADDR_W-1:0]   addr,
  output logic [NUM_CH*SIZE_W-1:0]   count,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          done,
  output logic                       done_all,
  output logic [NUM_CH*2-1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WORK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Largest run a channel can hold: one token per memory word.
  localparam logic [SIZE_W-1:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state      [NUM_CH];
  logic [1:0]        w_state_nxt  [NUM_CH];
  logic [SIZE_W-1:0] r_size_q     [NUM_CH];
  logic [SIZE_W-1:0] r_count      [NUM_CH];
  logic [ADDR_W-1:0] r_addr       [NUM_CH];
  logic [SIZE_W-1:0] w_size_in    [NUM_CH];
  logic [SIZE_W-1:0] w_size_clamp [NUM_CH];
  logic [NUM_CH-1:0] w_last;
  logic [NUM_CH-1:0] w_wren;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_done;
  logic              w_all_done;
  logic              r_done_all;

  // Unpack requested sizes, clamp to memory depth, and detect the final token.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_size_in[i]    = size[i*SIZE_W +: SIZE_W];
      w_size_clamp[i] = (w_size_in[i] > MAX_SIZE) ? MAX_SIZE : w_size_in[i];
      w_last[i]       = (r_count[i] == (r_size_q[i] - SIZE_W'(1)));
    end
  end

  assign w_all_done = &w_done;

  // State register for every channel controller.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Next-state logic: clear overrides everything; DONE releases only together.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (clear) begin
        w_state_nxt[i] = S_IDLE;
      end else begin
        case (r_state[i])
          S_IDLE: if (start) w_state_nxt[i] = (w_size_in[i] == '0) ? S_DONE : S_WORK;
          S_WORK: if (wr[i] && w_last[i]) w_state_nxt[i] = S_DONE;
          S_DONE: if (w_all_done) w_state_nxt[i] = S_IDLE;
          default: w_state_nxt[i] = S_IDLE;
        endcase
      end
    end
  end

  // Output decode purely from state (wren additionally passes wr through in WORK).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_full[i] = 1'b1;
      w_done[i] = 1'b0;
      w_wren[i] = 1'b0;
      case (r_state[i])
        S_WORK: begin
          w_full[i] = 1'b0;
          w_wren[i] = wr[i];
        end
        S_DONE: w_done[i] = 1'b1;
        default: ;
      endcase
    end
  end

  // Per-channel run size, write counter and address, plus the done_all pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_done_all <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_size_q[i] <= '0;
        r_count[i]  <= '0;
        r_addr[i]   <= '0;
      end
    end else if (clear) begin
      r_done_all <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
        r_addr[i]  <= '0;
      end
    end else begin
      // All channels leave DONE on this same edge, so this is a single pulse.
      r_done_all <= w_all_done;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_state[i] == S_IDLE && start) begin
          r_size_q[i] <= w_size_clamp[i];
          r_count[i]  <= '0;
          r_addr[i]   <= '0;
        end else if (w_wren[i]) begin
          r_count[i] <= r_count[i] + SIZE_W'(1);
          r_addr[i]  <= r_addr[i] + ADDR_W'(1);
        end
      end
    end
  end

  // Pack per-channel values onto the flat output buses.
  always_comb begin
    addr      = '0;
    count     = '0;
    state_dbg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      addr[i*ADDR_W +: ADDR_W]  = r_addr[i];
      count[i*SIZE_W +: SIZE_W] = r_count[i];
      state_dbg[i*2 +: 2]       = r_state[i];
    end
  end

  assign wren     = w_wren;
  assign full     = w_full;
  assign done     = w_done;
  assign done_all = r_done_all;

endmodule

// File: tb/tb_back_end_mc.sv
// tb_back_end_mc: directed test of back_end_mc with NUM_CH=2, ADDR_W=10.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_back_end_mc;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 10;
  localparam int SIZE_W = ADDR_W + 1;

  logic                     aclk;
  logic                     aresetn;
  logic                     start;
  logic                     clear;
  logic [NUM_CH*SIZE_W-1:0] size;
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH-1:0]        wren;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*SIZE_W-1:0] count;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        done;
  logic                     done_all;
  logic [NUM_CH*2-1:0]      state_dbg;

  int total;
  int bad;
  int n0;
  int n1;
  int nda;
  logic [ADDR_W-1:0] exp_q[$];

  back_end_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .clear     (clear),
    .size      (size),
    .wr        (wr),
    .wren      (wren),
    .addr      (addr),
    .count     (count),
    .full      (full),
    .done      (done),
    .done_all  (done_all),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    aresetn = 1'b0; start = 1'b0; clear = 1'b0; size = '0; wr = '0;
    #1;
    chk("rst_full", full, 2'b11);
    chk("rst_wren", wren, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_addr", addr, 0);
    chk("rst_done_all", done_all, 0);
    @(negedge aclk); aresetn = 1'b1;

    // 1: async reset in the middle of a run
    @(negedge aclk); size = {11'd7, 11'd7}; start = 1'b1;
    @(negedge aclk); start = 1'b0; wr = 2'b11; #1;
    chk("t1_wren_work", wren, 2'b11);
    chk("t1_full_work", full, 2'b00);
    @(negedge aclk);
    @(negedge aclk); #1;
    chk("t1_count_before", count[10:0], 2);
    aresetn = 1'b0; #1;
    chk("t1_full", full, 2'b11);
    chk("t1_wren", wren, 2'b00);
    chk("t1_done", done, 2'b00);
    chk("t1_count", count, 0);
    chk("t1_addr", addr, 0);
    chk("t1_done_all", done_all, 0);
    wr = 2'b00;
    @(negedge aclk); aresetn = 1'b1;

    // 2: sizes {ch1=5, ch0=3}, continuous wr
    for (int a = 0; a < 5; a++) exp_q.push_back(ADDR_W'(a));
    @(negedge aclk); size = {11'd5, 11'd3}; start = 1'b1;
    @(negedge aclk); start = 1'b0; wr = 2'b11;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge aclk);
      #1;
      chk("t2_wren1", wren[1], 1);
      chk("t2_wren0", wren[0], (k < 3) ? 1 : 0);
      chk("t2_addr0", addr[9:0], (k < 3) ? k : 3);
      chk("t2_done0", done[0], (k >= 3) ? 1 : 0);
      if (wren[1] && exp_q.size() > 0) chk("t2_addr1", addr[19:10], exp_q.pop_front());
    end
    @(negedge aclk); wr = 2'b00; #1;
    chk("t2_done_both", done, 2'b11);
    chk("t2_full_both", full, 2'b11);
    chk("t2_no_done_all_yet", done_all, 0);
    chk("t2_count0", count[10:0], 3);
    chk("t2_count1", count[21:11], 5);
    chk("t2_q_empty", exp_q.size(), 0);
    @(negedge aclk); #1;
    chk("t2_done_all", done_all, 1);
    chk("t2_idle_done", done, 2'b00);
    chk("t2_idle_state", state_dbg, 0);
    chk("t2_hold_count0", count[10:0], 3);
    @(negedge aclk); #1;
    chk("t2_done_all_fall", done_all, 0);

    // 3: ch0 size 0, ch1 size 2; start held on the done_all edge
    @(negedge aclk); size = {11'd2, 11'd0}; start = 1'b1;
    @(negedge aclk); start = 1'b0; #1;
    chk("t3_done0_early", done, 2'b01);
    chk("t3_full", full, 2'b01);
    chk("t3_no_wren", wren, 2'b00);
    wr = 2'b11; #1;
    chk("t3_wren_ch1_only", wren, 2'b10);
    @(negedge aclk); #1;
    chk("t3_wren2", wren, 2'b10);
    chk("t3_addr1", addr[19:10], 1);
    chk("t3_no_done_all", done_all, 0);
    @(negedge aclk); wr = 2'b00; start = 1'b1; #1;
    chk("t3_done_both", done, 2'b11);
    chk("t3_no_done_all2", done_all, 0);
    chk("t3_count1", count[21:11], 2);
    @(negedge aclk); start = 1'b0; #1;
    chk("t3_done_all", done_all, 1);
    chk("t3_start_ignored", state_dbg, 0);
    chk("t3_full_idle", full, 2'b11);
    chk("t3_count0", count[10:0], 0);
    @(negedge aclk); #1;
    chk("t3_done_all_fall", done_all, 0);

    // 4: gappy wr on ch0 (size 4), ch1 size 1, wr forced high in IDLE/DONE
    @(negedge aclk); wr = 2'b11; size = {11'd1, 11'd4}; #1;
    chk("t4_idle_wren", wren, 2'b00);
    @(negedge aclk); start = 1'b1; #1;
    chk("t4_start_wren", wren, 2'b00);
    n0 = 0; n1 = 0; nda = 0;
    @(negedge aclk); start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge aclk);
      wr = (c < 8) ? {1'b1, (c % 2 == 0)} : 2'b11;
      #1;
      if (c == 0) begin
        chk("t4_size1_addr", addr[19:10], 0);
        chk("t4_size1_wren", wren[1], 1);
      end
      n0 += int'(wren[0]);
      n1 += int'(wren[1]);
      nda += int'(done_all);
    end
    wr = 2'b00;
    chk("t4_pulses0", n0, 4);
    chk("t4_pulses1", n1, 1);
    chk("t4_done_all_pulses", nda, 1);
    chk("t4_count0", count[10:0], 4);
    chk("t4_addr0", addr[9:0], 4);
    chk("t4_count1", count[21:11], 1);
    chk("t4_addr1", addr[19:10], 1);

    // 5: clear after 2 of 5 writes, then a clean rerun
    @(negedge aclk); size = {11'd5, 11'd5}; start = 1'b1;
    @(negedge aclk); start = 1'b0; wr = 2'b11;
    @(negedge aclk);
    @(negedge aclk); wr = 2'b00; clear = 1'b1; start = 1'b1; #1;
    chk("t5_count_pre", count[10:0], 2);
    @(negedge aclk); clear = 1'b0; start = 1'b0; #1;
    chk("t5_idle", state_dbg, 0);
    chk("t5_full", full, 2'b11);
    chk("t5_count", count, 0);
    chk("t5_addr", addr, 0);
    chk("t5_done_all", done_all, 0);
    @(negedge aclk); #1;
    chk("t5_done_all2", done_all, 0);
    @(negedge aclk); size = {11'd1, 11'd1}; start = 1'b1;
    @(negedge aclk); start = 1'b0; wr = 2'b11; #1;
    chk("t5_rerun_wren", wren, 2'b11);
    chk("t5_rerun_addr", addr, 0);
    @(negedge aclk); wr = 2'b00; #1;
    chk("t5_rerun_done", done, 2'b11);
    @(negedge aclk); #1;
    chk("t5_rerun_done_all", done_all, 1);
    chk("t5_rerun_count0", count[10:0], 1);
    chk("t5_rerun_count1", count[21:11], 1);

    // 6: full-depth run; ch1 requests 2047 and is clamped to 1024
    @(negedge aclk); size = {11'd2047, 11'd1024}; start = 1'b1;
    @(negedge aclk); start = 1'b0; wr = 2'b11;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) @(negedge aclk);
      #1;
      n0 += int'(wren[0]);
      n1 += int'(wren[1]);
      if (k == 1023) begin
        chk("t6_last_addr0", addr[9:0], 1023);
        chk("t6_last_addr1", addr[19:10], 1023);
        chk("t6_not_done", done, 2'b00);
      end
    end
    @(negedge aclk); wr = 2'b00; #1;
    chk("t6_pulses0", n0, 1024);
    chk("t6_pulses1", n1, 1024);
    chk("t6_done", done, 2'b11);
    chk("t6_count0", count[10:0], 1024);
    chk("t6_count1", count[21:11], 1024);
    chk("t6_addr_wrap0", addr[9:0], 0);
    chk("t6_addr_wrap1", addr[19:10], 0);
    @(negedge aclk); #1;
    chk("t6_done_all", done_all, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
